// File: rtl/step_dir_driver.sv
// Turns interpolator step strobes into step/dir drive pulses with guaranteed dir setup and pulse width.
// Step rises one edge after a strobe (DIR_SETUP edges later if dir must flip); excess strobes queue in a saturating counter.

module step_dir_axis #(
   parameter int PULSE_W   = 4,
   parameter int DIR_SETUP = 2,
   parameter int PEND_W    = 4
) (
   input  logic               pulse_clk,
   input  logic               sys_rst_l,
   input  logic               acc,
   input  logic               dec,
   input  logic               pos_load,
   input  logic signed [15:0] load_val,
   output logic               step,
   output logic               dir,
   output logic signed [15:0] pos,
   output logic               busy,
   output logic               ovf
);

   localparam int CNT_MAX = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int EXT_W   = PEND_W + 2;
   localparam logic signed [EXT_W-1:0] PEND_MAX = EXT_W'(2 ** (PEND_W - 1) - 1);
   localparam logic signed [EXT_W-1:0] PEND_MIN = -PEND_MAX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } axis_st_e;

   axis_st_e                  st_q, st_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic signed [PEND_W-1:0]  pend_q, pend_d;
   logic                      dir_q, dir_d;
   logic                      step_q, step_d;
   logic signed [15:0]        pos_q, pos_d;

   logic                      pend_nz;
   logic                      want_pos;
   logic                      cnt_zero;
   logic                      decide_en;
   logic                      enter_high;
   logic                      enter_low;
   logic                      dir_flip;
   logic signed [EXT_W-1:0]   base_x;
   logic signed [EXT_W-1:0]   cand_x;

   always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         st_q   <= ST_IDLE;
         cnt_q  <= '0;
         pend_q <= '0;
         dir_q  <= 1'b1;
         step_q <= 1'b0;
         pos_q  <= '0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         pos_q  <= pos_d;
      end
   end

   // IDLE, an expired SETUP and an expired LOW all make the same queue-driven choice.
   always_comb begin
      pend_nz   = (pend_q != '0);
      want_pos  = ~pend_q[PEND_W-1];
      cnt_zero  = (cnt_q == '0);
      decide_en = (st_q == ST_IDLE) ||
                  (((st_q == ST_SETUP) || (st_q == ST_LOW)) && cnt_zero);
      st_d      = st_q;
      if (pos_load) begin
         st_d = ST_IDLE;
      end else if (st_q == ST_HIGH) begin
         if (cnt_zero) st_d = ST_LOW;
      end else if (decide_en) begin
         if (!pend_nz)               st_d = ST_IDLE;
         else if (want_pos != dir_q) st_d = ST_SETUP;
         else                        st_d = ST_HIGH;
      end
   end

   always_comb begin
      enter_high = (st_d == ST_HIGH) && (st_q != ST_HIGH);
      enter_low  = (st_d == ST_LOW)  && (st_q == ST_HIGH);
      dir_flip   = (st_d == ST_SETUP) && decide_en;

      cnt_d = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
      if (dir_flip)                cnt_d = CNT_W'(DIR_SETUP - 1);
      if (enter_high || enter_low) cnt_d = CNT_W'(PULSE_W - 1);

      dir_d  = dir_flip ? ~dir_q : dir_q;
      step_d = step_q;
      pos_d  = pos_q;
      if (enter_high) begin
         step_d = 1'b1;
         pos_d  = pos_q + (dir_q ? 16'h0001 : 16'hFFFF);
      end
      if (enter_low) step_d = 1'b0;

      // A step only starts when the queue sign matches dir, so consuming moves toward zero.
      base_x = EXT_W'(pend_q);
      if (enter_high) base_x = dir_q ? base_x - EXT_W'(1) : base_x + EXT_W'(1);
      case ({acc, dec})
         2'b10:   cand_x = base_x + EXT_W'(1);
         2'b01:   cand_x = base_x - EXT_W'(1);
         default: cand_x = base_x;
      endcase
      ovf    = 1'b0;
      pend_d = cand_x[PEND_W-1:0];
      if ((cand_x > PEND_MAX) || (cand_x < PEND_MIN)) begin
         ovf    = 1'b1;
         pend_d = base_x[PEND_W-1:0];
      end

      if (pos_load) begin
         pend_d = '0;
         ovf    = 1'b0;
         step_d = 1'b0;
         pos_d  = load_val;
      end
   end

   assign step = step_q;
   assign dir  = dir_q;
   assign pos  = pos_q;
   assign busy = (st_q != ST_IDLE) || pend_nz;

endmodule

module step_dir_driver #(
   parameter int PULSE_W   = 4,
   parameter int DIR_SETUP = 2,
   parameter int PEND_W    = 4
) (
   input  logic               pulse_clk,
   input  logic               sys_rst_l,
   input  logic               X_acc,
   input  logic               X_dec,
   input  logic               Y_acc,
   input  logic               Y_dec,
   input  logic               draw_overH,
   input  logic               pos_load,
   input  logic signed [15:0] load_x,
   input  logic signed [15:0] load_y,
   output logic               x_step,
   output logic               y_step,
   output logic               x_dir,
   output logic               y_dir,
   output logic signed [15:0] x_pos,
   output logic signed [15:0] y_pos,
   output logic               busy,
   output logic               move_doneH,
   output logic               ovf_err
);

   logic x_busy, y_busy;
   logic x_ovf, y_ovf;
   logic over_seen_q, over_seen_d;
   logic move_done_q, move_done_d;
   logic ovf_err_q, ovf_err_d;

   step_dir_axis #(
      .PULSE_W   (PULSE_W),
      .DIR_SETUP (DIR_SETUP),
      .PEND_W    (PEND_W)
   ) u_axis_x (
      .pulse_clk (pulse_clk),
      .sys_rst_l (sys_rst_l),
      .acc       (X_acc),
      .dec       (X_dec),
      .pos_load  (pos_load),
      .load_val  (load_x),
      .step      (x_step),
      .dir       (x_dir),
      .pos       (x_pos),
      .busy      (x_busy),
      .ovf       (x_ovf)
   );

   step_dir_axis #(
      .PULSE_W   (PULSE_W),
      .DIR_SETUP (DIR_SETUP),
      .PEND_W    (PEND_W)
   ) u_axis_y (
      .pulse_clk (pulse_clk),
      .sys_rst_l (sys_rst_l),
      .acc       (Y_acc),
      .dec       (Y_dec),
      .pos_load  (pos_load),
      .load_val  (load_y),
      .step      (y_step),
      .dir       (y_dir),
      .pos       (y_pos),
      .busy      (y_busy),
      .ovf       (y_ovf)
   );

   always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         over_seen_q <= 1'b0;
         move_done_q <= 1'b0;
         ovf_err_q   <= 1'b0;
      end else begin
         over_seen_q <= over_seen_d;
         move_done_q <= move_done_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   // Completion waits for the queue to drain, not just for draw_overH.
   always_comb begin
      move_done_d = over_seen_q && !x_busy && !y_busy;
      over_seen_d = draw_overH || (over_seen_q && !move_done_d);
      ovf_err_d   = ovf_err_q || x_ovf || y_ovf;
      if (pos_load) begin
         move_done_d = 1'b0;
         over_seen_d = 1'b0;
         ovf_err_d   = 1'b0;
      end
   end

   assign busy       = x_busy || y_busy;
   assign move_doneH = move_done_q;
   assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_step_dir_driver.sv
// Bench for step_dir_driver: directed scenarios plus random strobes against a timestamp-based reference model.
module tb_step_dir_driver;
   localparam int PW   = 4;
   localparam int DS   = 2;
   localparam int PMAX = 7;

   logic        pulse_clk = 1'b0;
   logic        sys_rst_l = 1'b1;
   logic        X_acc = 1'b0, X_dec = 1'b0, Y_acc = 1'b0, Y_dec = 1'b0;
   logic        draw_overH = 1'b0, pos_load = 1'b0;
   logic [15:0] load_x = '0, load_y = '0;
   logic        x_step, y_step, x_dir, y_dir;
   logic [15:0] x_pos, y_pos;
   logic        busy, move_doneH, ovf_err;

   int checks = 0;
   int failures = 0;

   // reference model: per-axis mode 0 idle, 1 waiting for a rise at m_rise, 2 pulse that rose at m_rise
   int          m_pend[2];
   logic        m_dir[2];
   logic [15:0] m_pos[2];
   int          m_mode[2];
   int          m_rise[2];
   logic        m_ovf, m_over, m_done;
   int          mn = 0;

   // monitors
   int   te;
   int   x_rises, y_rises, x_dir_chg, done_cnt, done_e, y_last_fall_e;
   int   x_rise_e[$];
   logic px_step, py_step, px_dir;

   always #5 pulse_clk = ~pulse_clk;

   step_dir_driver #(.PULSE_W(PW), .DIR_SETUP(DS), .PEND_W(4)) dut (
      .pulse_clk  (pulse_clk),
      .sys_rst_l  (sys_rst_l),
      .X_acc      (X_acc),
      .X_dec      (X_dec),
      .Y_acc      (Y_acc),
      .Y_dec      (Y_dec),
      .draw_overH (draw_overH),
      .pos_load   (pos_load),
      .load_x     (load_x),
      .load_y     (load_y),
      .x_step     (x_step),
      .y_step     (y_step),
      .x_dir      (x_dir),
      .y_dir      (y_dir),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .busy       (busy),
      .move_doneH (move_doneH),
      .ovf_err    (ovf_err)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_busy(input int a);
      return (m_mode[a] != 0) || (m_pend[a] != 0);
   endfunction

   function automatic logic m_step(input int a);
      return (m_mode[a] == 2) && (mn < m_rise[a] + PW);
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         m_pend[a] = 0; m_dir[a] = 1'b1; m_pos[a] = '0; m_mode[a] = 0; m_rise[a] = 0;
      end
      m_ovf = 1'b0; m_over = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_edge();
      logic [1:0]  acc_i, dec_i;
      logic [15:0] ld[2];
      logic        sv_dir;
      logic        busy_pre;
      int          cons, cand;
      acc_i = {Y_acc, X_acc};
      dec_i = {Y_dec, X_dec};
      ld[0] = load_x;
      ld[1] = load_y;
      mn++;
      busy_pre = m_busy(0) || m_busy(1);
      m_done   = m_over && !busy_pre;
      m_over   = draw_overH || (m_over && !m_done);
      for (int a = 0; a < 2; a++) begin
         sv_dir = m_dir[a];
         cons   = 0;
         if (m_mode[a] == 0 || (m_mode[a] == 1 && mn == m_rise[a]) ||
             (m_mode[a] == 2 && mn == m_rise[a] + 2 * PW)) begin
            if (m_pend[a] == 0) begin
               m_mode[a] = 0;
            end else if ((m_pend[a] > 0) != m_dir[a]) begin
               m_dir[a]  = !m_dir[a];
               m_mode[a] = 1;
               m_rise[a] = mn + DS;
            end else begin
               m_mode[a] = 2;
               m_rise[a] = mn;
               m_pos[a]  = m_pos[a] + (m_dir[a] ? 16'h0001 : 16'hFFFF);
               cons      = m_dir[a] ? -1 : 1;
            end
         end
         cand = m_pend[a] + int'(acc_i[a]) - int'(dec_i[a]) + cons;
         if (cand > PMAX || cand < -PMAX) begin
            m_pend[a] = m_pend[a] + cons;
            m_ovf     = 1'b1;
         end else begin
            m_pend[a] = cand;
         end
         if (pos_load) begin
            m_pos[a] = ld[a]; m_pend[a] = 0; m_mode[a] = 0; m_dir[a] = sv_dir;
         end
      end
      if (pos_load) begin
         m_ovf = 1'b0; m_over = 1'b0; m_done = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk_eq("x_step", x_step, m_step(0));
      chk_eq("y_step", y_step, m_step(1));
      chk_eq("x_dir", x_dir, m_dir[0]);
      chk_eq("y_dir", y_dir, m_dir[1]);
      chk_eq("x_pos", x_pos, m_pos[0]);
      chk_eq("y_pos", y_pos, m_pos[1]);
      chk_eq("busy", busy, m_busy(0) || m_busy(1));
      chk_eq("move_doneH", move_doneH, m_done);
      chk_eq("ovf_err", ovf_err, m_ovf);
      if (x_step && !px_step) begin
         x_rises++;
         x_rise_e.push_back(te);
      end
      if (y_step && !py_step) y_rises++;
      if (!y_step && py_step) y_last_fall_e = te;
      if (x_dir !== px_dir) x_dir_chg++;
      if (move_doneH) begin
         done_cnt++;
         done_e = te;
      end
      px_step = x_step;
      py_step = y_step;
      px_dir  = x_dir;
   endtask

   task automatic cyc();
      @(posedge pulse_clk);
      te++;
      model_edge();
      #1;
      compare_all();
      X_acc = 1'b0; X_dec = 1'b0; Y_acc = 1'b0; Y_dec = 1'b0;
      draw_overH = 1'b0; pos_load = 1'b0;
   endtask

   task automatic start_test();
      te = -1;
      x_rises = 0; y_rises = 0; x_dir_chg = 0; done_cnt = 0; done_e = -1; y_last_fall_e = -1;
      x_rise_e.delete();
   endtask

   task automatic do_reset();
      X_acc = 1'b0; X_dec = 1'b0; Y_acc = 1'b0; Y_dec = 1'b0;
      draw_overH = 1'b0; pos_load = 1'b0;
      sys_rst_l = 1'b0;
      #1;
      chk_eq("rst_x_step", x_step, 0);
      chk_eq("rst_y_step", y_step, 0);
      chk_eq("rst_x_dir", x_dir, 1);
      chk_eq("rst_y_dir", y_dir, 1);
      chk_eq("rst_x_pos", x_pos, 0);
      chk_eq("rst_y_pos", y_pos, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", move_doneH, 0);
      chk_eq("rst_ovf", ovf_err, 0);
      model_reset();
      px_step = 1'b0; py_step = 1'b0; px_dir = 1'b1;
      @(negedge pulse_clk);
      sys_rst_l = 1'b1;
   endtask

   initial begin
      int unsigned px, pxd, py, pyd;
      #2;
      do_reset();

      // single step, no dir change
      start_test();
      X_acc = 1'b1; cyc();
      cyc();
      chk_eq("t1_step_E1", x_step, 1);
      chk_eq("t1_pos_E1", x_pos, 16'd1);
      chk_eq("t1_dir_E1", x_dir, 1);
      repeat (3) cyc();
      chk_eq("t1_step_E4", x_step, 1);
      cyc();
      chk_eq("t1_step_E5", x_step, 0);
      repeat (3) cyc();
      chk_eq("t1_busy_E8", busy, 1);
      cyc();
      chk_eq("t1_busy_E9", busy, 0);
      chk_eq("t1_y_pos", y_pos, 0);
      chk_eq("t1_pulses", x_rises, 1);

      // single step needing a dir change
      do_reset();
      start_test();
      X_dec = 1'b1; cyc();
      cyc();
      chk_eq("t2_dir_E1", x_dir, 0);
      chk_eq("t2_step_E1", x_step, 0);
      cyc();
      chk_eq("t2_step_E2", x_step, 0);
      cyc();
      chk_eq("t2_step_E3", x_step, 1);
      chk_eq("t2_pos_E3", x_pos, 16'hFFFF);
      repeat (10) cyc();

      // queue saturation
      do_reset();
      start_test();
      for (int i = 0; i < 12; i++) begin
         X_acc = 1'b1;
         cyc();
         if (i == 7) chk_eq("t3_ovf_E7", ovf_err, 0);
         if (i == 8) chk_eq("t3_ovf_E8", ovf_err, 1);
      end
      repeat (80) cyc();
      chk_eq("t3_pulses", x_rises, 9);
      chk_eq("t3_pos", x_pos, 16'd9);
      if (x_rise_e.size() >= 9) begin
         chk_eq("t3_first_rise", x_rise_e[0], 1);
         chk_eq("t3_period", x_rise_e[1] - x_rise_e[0], 2 * PW);
         chk_eq("t3_last_period", x_rise_e[8] - x_rise_e[7], 2 * PW);
      end

      // cancellation
      do_reset();
      start_test();
      X_acc = 1'b1; cyc();
      cyc();
      X_acc = 1'b1; cyc();
      X_dec = 1'b1; cyc();
      repeat (20) cyc();
      chk_eq("t4_pulses", x_rises, 1);
      chk_eq("t4_pos", x_pos, 16'd1);
      chk_eq("t4_dir_toggles", x_dir_chg, 0);

      // completion after queued steps drain
      do_reset();
      start_test();
      repeat (3) begin
         Y_acc = 1'b1;
         cyc();
      end
      draw_overH = 1'b1; cyc();
      chk_eq("t5_busy_at_over", busy, 1);
      repeat (30) cyc();
      chk_eq("t5_done_cnt", done_cnt, 1);
      chk_eq("t5_done_edge", done_e, y_last_fall_e + PW + 1);
      chk_eq("t5_done_E26", done_e, 26);
      chk_eq("t5_y_pulses", y_rises, 3);
      chk_eq("t5_y_pos", y_pos, 16'd3);

      // load mid-pulse with a strobe in the same cycle
      do_reset();
      start_test();
      repeat (3) begin
         X_acc = 1'b1;
         cyc();
      end
      chk_eq("t6_step_pre", x_step, 1);
      pos_load = 1'b1; load_x = 16'd100; X_acc = 1'b1; cyc();
      chk_eq("t6_step", x_step, 0);
      chk_eq("t6_pos", x_pos, 16'd100);
      chk_eq("t6_busy", busy, 0);
      chk_eq("t6_ovf", ovf_err, 0);
      repeat (30) cyc();
      chk_eq("t6_pulses", x_rises, 1);
      chk_eq("t6_pos_after", x_pos, 16'd100);

      // async reset mid-pulse (do_reset checks the step drop before any edge)
      start_test();
      X_acc = 1'b1; cyc();
      X_acc = 1'b1; cyc();
      chk_eq("t7_step_pre", x_step, 1);
      do_reset();

      // randomized traffic against the model
      start_test();
      px = 0; pxd = 0; py = 0; pyd = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 400 == 0) begin
            px  = $urandom_range(0, 70);
            pxd = $urandom_range(0, 70);
            py  = $urandom_range(0, 70);
            pyd = $urandom_range(0, 70);
         end
         if (i == 1700) do_reset();
         X_acc      = ($urandom_range(0, 99) < px);
         X_dec      = ($urandom_range(0, 99) < pxd);
         Y_acc      = ($urandom_range(0, 99) < py);
         Y_dec      = ($urandom_range(0, 99) < pyd);
         draw_overH = ($urandom_range(0, 99) < 4);
         pos_load   = ($urandom_range(0, 299) == 0) || (i == 100);
         load_x     = (i == 100) ? 16'h7FFF : 16'($urandom);
         load_y     = (i == 100) ? 16'h8000 : 16'($urandom);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/step_dir_driver.md
# step_dir_driver

Receiving end of the interpolator step interface. Consumes the single-cycle X_acc/X_dec/Y_acc/Y_dec strobes and draw_overH from the circular interpolator. Converts them into stepper-drive step/dir signals with guaranteed direction setup and pulse width, queuing steps that arrive faster than the drive can emit them. Tracks the emitted absolute position per axis and reports completion once all queued steps have been emitted.

## Interface
- PULSE_W, 4: step high time and low time, in pulse_clk cycles; must be ≥1.
- DIR_SETUP, 2: cycles from a dir change to the next step rising edge; must be ≥1.
- PEND_W, 4: width of the signed per-axis pending counter; legal range ±(2^(PEND_W−1)−1), i.e. ±7.

Ports:
- pulse_clk  in  1  clock; all logic on posedge.
- sys_rst_l  in  1  reset, asynchronous, active-low.
- X_acc, X_dec, Y_acc, Y_dec  in  1 each  step strobes: acc = +1, dec = −1.
- draw_overH  in  1  end-of-move strobe from the interpolator.
- pos_load  in  1  synchronous position load and queue flush.
- load_x, load_y  in  16 signed each  values loaded by pos_load.
- x_step, y_step  out  1 each  step pulses.
- x_dir, y_dir  out  1 each  direction: 1 = positive.
- x_pos, y_pos  out  16 signed each  emitted position.
- busy  out  1  any axis non-IDLE or any pending count ≠0.
- move_doneH  out  1  one-cycle completion pulse.
- ovf_err  out  1  sticky queue-overflow flag.

## Operation
- Reset (async) values:
  - step = 0, dir = 1, pos = 0, pending = 0.
  - busy = 0, move_doneH = 0, ovf_err = 0.
  - Both axis FSMs in IDLE; over_seen = 0.
- Pending counter, per axis, updated every edge:
  - net = (acc) − (dec) − (consume), where consume = 1 toward zero on entry to HIGH.
  - acc and dec together give net 0 from the strobes.
  - An opposite strobe cancels a queued step; no pulse is emitted for it.
  - If the new value would exceed the legal range, the strobe contribution is dropped, any consume still applies, and ovf_err sets.
- Axis FSM states: IDLE, SETUP, HIGH, LOW. A down-counter loads on each state entry.
  - IDLE: if pending ≠0, the wanted direction is (pending > 0).
    - Wanted direction ≠ dir: toggle dir at this edge and go to SETUP for DIR_SETUP cycles.
    - Otherwise go to HIGH.
  - SETUP → HIGH when the count expires.
  - HIGH entry: step = 1, pos ± 1 per dir (16-bit two's-complement wrap), consume one pending step. Hold PULSE_W cycles, then go to LOW (step = 0).
  - LOW, after PULSE_W cycles:
    - pending ≠0, same direction → HIGH directly (no idle cycle).
    - pending ≠0, opposite direction → toggle dir, go to SETUP.
    - pending = 0 → IDLE.
- Completion:
  - draw_overH sets over_seen.
  - When over_seen = 1, both FSMs are IDLE and both pendings are 0: move_doneH = 1 for one cycle, and over_seen clears.
  - draw_overH arriving while already idle gives move_doneH on the next edge.
- pos_load, at the edge it is sampled:
  - pos = load_x/load_y; pending = 0; FSMs → IDLE; step = 0.
  - ovf_err and over_seen clear; dir is unchanged.
  - It overrides any strobe or step entry in the same cycle.
- busy is combinational from state and pending.

## Timing
- Strobe sampled at edge E0; same direction as dir → step rises at E1.
- Needs a dir change → dir toggles at E1 and step rises at E1+DIR_SETUP.
- Step high exactly PULSE_W cycles and low at least PULSE_W cycles; minimum step period 2·PULSE_W.
- pos changes at the step rising edge.
- Reset asserted mid-pulse: step drops immediately (async). Queued steps are lost.

## Test plan
Defaults PULSE_W=4, DIR_SETUP=2, PEND_W=4.
- Single step, no dir change: reset, one X_acc at E0 → x_dir stays 1; x_step high E1–E5, low E5–E9; x_pos = 1; busy falls at E9; y outputs unchanged.
- Single step with dir change: one X_dec from reset → x_dir = 0 at E1; x_step rises at E3; x_pos = 0xFFFF.
- Queue saturation: X_acc held for edges E0–E11 → ovf_err sets at E8; strobes at E8, E10, E11 dropped; exactly 9 x_step pulses at period 8; final x_pos = 9.
- Cancellation: X_acc at E0, then X_acc at E2 and X_dec at E3 → exactly 1 pulse; x_pos = 1; no dir toggle.
- Completion with queued steps: 3 Y_acc strobes, then draw_overH while busy → move_doneH is a single pulse one edge after y_step's last low phase ends; y_pos = 3.
- Load mid-pulse: pos_load with load_x = 100 during x_step high and pending 2 → x_step = 0 next edge; x_pos = 100; pending 0; ovf_err 0; no further pulses.
